// File: rtl/div_host_uart_if.sv
// div_host_uart_if -- byte-stream link between the division host and the
// UART byte transmitter/receiver.
//   tx_data/tx_valid/tx_ready : host -> transmitter, valid/ready handshake
//   rx_data/rx_valid          : receiver -> host, one-cycle strobe
// master: the host side (div_host_uart); slave: the UART side.
interface div_host_uart_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  rx_data,
      input  rx_valid
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output rx_data,
      output rx_valid
   );
endinterface

// File: rtl/div_host_uart.sv
// div_host_uart -- sends a 16-bit dividend/divisor pair to a remote divider
// over a UART byte link and collects the 16-bit quotient/remainder reply.
//   clk, rst             : clock, synchronous active-high reset
//   start                : one-cycle request (ignored while busy)
//   dividend, divisor    : operands, latched on an accepted start
//   uart                 : byte link (tx_data/tx_valid/tx_ready, rx_data/rx_valid)
//   busy                 : transaction in progress (SEND, RECV, FIN)
//   done                 : one-cycle pulse at the end of a transaction
//   quotient, remainder  : last successfully received result
//   timeout_err          : 1 if the last transaction timed out
module div_host_uart #(
   parameter int unsigned TIMEOUT_MAX = 50000000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [15:0]     dividend,
   input  logic [15:0]     divisor,
   div_host_uart_if.master uart,
   output logic            busy,
   output logic            done,
   output logic [15:0]     quotient,
   output logic [15:0]     remainder,
   output logic            timeout_err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEND = 2'd1;
   localparam logic [1:0] RECV = 2'd2;
   localparam logic [1:0] FIN  = 2'd3;

   localparam int unsigned CW = (TIMEOUT_MAX < 2) ? 1 : $clog2(TIMEOUT_MAX + 1);
   // The timeout fires on the cycle whose increment would bring the counter
   // to TIMEOUT_MAX-1, so comparing against TIMEOUT_MAX-2 gives done exactly
   // TIMEOUT_MAX cycles after the last reply byte.
   localparam int unsigned TO_LAST = (TIMEOUT_MAX < 2) ? 0 : TIMEOUT_MAX - 2;

   logic [1:0]    state;
   logic [1:0]    idx;
   logic [15:0]   a_q;
   logic [15:0]   b_q;
   logic [7:0]    sh0;
   logic [7:0]    sh1;
   logic [7:0]    sh2;
   logic [CW-1:0] to_cnt;
   logic [7:0]    tx_byte;

   always_comb begin
      tx_byte = '0;
      if (state == SEND) begin
         case (idx)
            2'd0:    tx_byte = a_q[7:0];
            2'd1:    tx_byte = a_q[15:8];
            2'd2:    tx_byte = b_q[7:0];
            default: tx_byte = b_q[15:8];
         endcase
      end
   end

   assign uart.tx_data  = tx_byte;
   assign uart.tx_valid = (state == SEND);
   assign busy          = (state != IDLE);
   assign done          = (state == FIN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         sh0         <= '0;
         sh1         <= '0;
         sh2         <= '0;
         to_cnt      <= '0;
         quotient    <= '0;
         remainder   <= '0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_q   <= dividend;
                  b_q   <= divisor;
                  idx   <= '0;
                  state <= SEND;
               end
            end
            SEND: begin
               if (uart.tx_ready) begin
                  if (idx == 2'd3) begin
                     idx    <= '0;
                     to_cnt <= '0;
                     state  <= RECV;
                  end else begin
                     idx <= idx + 2'd1;
                  end
               end
            end
            RECV: begin
               // A reply byte wins over a coincident timeout.
               if (uart.rx_valid) begin
                  to_cnt <= '0;
                  idx    <= idx + 2'd1;
                  case (idx)
                     2'd0: sh0 <= uart.rx_data;
                     2'd1: sh1 <= uart.rx_data;
                     2'd2: sh2 <= uart.rx_data;
                     default: begin
                        quotient    <= {sh1, sh0};
                        remainder   <= {uart.rx_data, sh2};
                        timeout_err <= 1'b0;
                        state       <= FIN;
                     end
                  endcase
               end else if (to_cnt >= CW'(TO_LAST)) begin
                  timeout_err <= 1'b1;
                  state       <= FIN;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_host_uart.sv
// tb_div_host_uart -- directed and randomized transactions against
// div_host_uart; expected bytes and results come from plain arithmetic on
// the operands (quotient/remainder, with divide-by-zero answered as
// FFFF/dividend by the remote end).
module tb_div_host_uart;
   localparam int M_RND  = 1;   // random tx_ready
   localparam int M_BP   = 2;   // 10-cycle stall on byte 2
   localparam int M_MIS  = 4;   // stray start / rx_valid
   localparam int M_FINS = 8;   // start pulsed in the FIN cycle
   localparam int M_RST  = 16;  // reset after the replies

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        timeout_err;

   div_host_uart_if bus ();

   div_host_uart #(.TIMEOUT_MAX(100)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .uart        (bus),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] exp_q;
   logic [15:0] exp_r;
   logic        exp_to;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [15:0] b);
      return (b == 16'd0) ? 16'hFFFF : a / b;
   endfunction

   function automatic logic [15:0] ref_r(input logic [15:0] a, input logic [15:0] b);
      return (b == 16'd0) ? a : a % b;
   endfunction

   task automatic check_outputs_zero;
      chk("rst_tx_valid", bus.tx_valid, 0);
      chk("rst_tx_data", bus.tx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_timeout_err", timeout_err, 0);
   endtask

   task automatic run_txn(input logic [15:0] a, input logic [15:0] b,
                          input int n_reply, input int mode);
      logic [7:0]  txq[$];
      logic [7:0]  rxq[$];
      logic [15:0] q;
      logic [15:0] r;
      int          k;
      int          cyc;
      int          stall;
      bit          rdy;

      txq = '{a[7:0], a[15:8], b[7:0], b[15:8]};
      q   = ref_q(a, b);
      r   = ref_r(a, b);
      rxq = '{q[7:0], q[15:8], r[7:0], r[15:8]};

      chk("idle_busy", busy, 0);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      dividend = 16'($urandom);
      divisor  = 16'($urandom);
      chk("busy_after_start", busy, 1);

      k = 0;
      cyc = 0;
      stall = 0;
      while (k < 4 && cyc < 200) begin
         chk("tx_valid", bus.tx_valid, 1);
         chk("tx_data", bus.tx_data, txq[k]);
         if ((mode & M_BP) != 0 && k == 1 && stall < 10) begin
            rdy = 1'b0;
            stall++;
         end else if ((mode & M_RND) != 0) begin
            rdy = 1'($urandom_range(0, 1));
         end else begin
            rdy = 1'b1;
         end
         bus.tx_ready = rdy;
         if ((mode & M_MIS) != 0) begin
            start        = 1'($urandom_range(0, 1));
            bus.rx_valid = 1'($urandom_range(0, 1));
            bus.rx_data  = 8'($urandom);
         end
         tick();
         cyc++;
         if (rdy) k++;
      end
      start        = 1'b0;
      bus.rx_valid = 1'b0;
      bus.tx_ready = 1'($urandom_range(0, 1));
      chk("send_transfers", k, 4);
      chk("tx_valid_off", bus.tx_valid, 0);

      for (int i = 0; i < n_reply; i++) begin
         repeat ($urandom_range(0, 3)) begin
            if ((mode & M_MIS) != 0) start = 1'($urandom_range(0, 1));
            chk("recv_no_done", done, 0);
            tick();
         end
         bus.rx_valid = 1'b1;
         bus.rx_data  = rxq[i];
         tick();
         bus.rx_valid = 1'b0;
         bus.rx_data  = 8'($urandom);
         start        = 1'b0;
         if (i < 3) chk("recv_partial_no_done", done, 0);
      end

      if ((mode & M_RST) != 0) begin
         rst = 1'b1;
         tick();
         rst = 1'b0;
         exp_q  = '0;
         exp_r  = '0;
         exp_to = 1'b0;
         check_outputs_zero();
         repeat (3) begin
            tick();
            chk("post_rst_no_done", done, 0);
            chk("post_rst_idle", busy, 0);
         end
         return;
      end

      if (n_reply == 4) begin
         chk("done_latency", done, 1);
         exp_q  = q;
         exp_r  = r;
         exp_to = 1'b0;
      end else begin
         cyc = 1;
         while (done !== 1'b1 && cyc < 300) begin
            tick();
            cyc++;
         end
         chk("timeout_latency", cyc, 100);
         exp_to = 1'b1;
      end
      chk("quotient", quotient, exp_q);
      chk("remainder", remainder, exp_r);
      chk("timeout_err", timeout_err, exp_to);

      if ((mode & M_FINS) != 0) start = 1'b1;
      tick();
      start = 1'b0;
      chk("done_one_cycle", done, 0);
      chk("busy_cleared", busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1);
   end

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;

      rst          = 1'b1;
      start        = 1'b0;
      dividend     = '0;
      divisor      = '0;
      bus.tx_ready = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = '0;
      exp_q        = '0;
      exp_r        = '0;
      exp_to       = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check_outputs_zero();

      // Nominal divide, divide-by-zero, backpressure, misuse.
      run_txn(16'h03E8, 16'h0007, 4, 0);
      chk("nominal_q_const", quotient, 16'h008E);
      chk("nominal_r_const", remainder, 16'h0006);
      run_txn(16'h1234, 16'h0000, 4, 0);
      chk("div0_q_const", quotient, 16'hFFFF);
      chk("div0_r_const", remainder, 16'h1234);
      run_txn(16'h03E8, 16'h0007, 4, M_BP);
      run_txn(16'h03E8, 16'h0007, 4, M_MIS);

      // Timeout after two reply bytes keeps the previous result.
      run_txn(16'hBEEF, 16'h0013, 2, 0);
      chk("timeout_keeps_q", quotient, 16'h008E);
      run_txn(16'h0064, 16'h0009, 4, M_FINS);
      run_txn(16'hFFFF, 16'h0001, 4, 0);

      // Reset part-way through the reply, then a clean transaction.
      run_txn(16'h4321, 16'h0005, 2, M_RST);
      run_txn(16'h03E8, 16'h0007, 4, 0);

      for (int t = 0; t < 10; t++) begin
         ra = 16'($urandom);
         rb = (t % 4 == 3) ? 16'h0000 : 16'($urandom_range(1, 300));
         run_txn(ra, rb, 4, M_RND | ((t % 2 == 1) ? M_MIS : 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/div_host_uart.md
DIV_HOST_UART -- requirements
Module: div_host_uart

Interface
REQ-001 Parameter TIMEOUT_MAX, default 50000000: maximum idle cycles allowed between reply bytes (1 s at 50 MHz).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to run one division transaction.
REQ-005 dividend  input  16  operand A; sampled on accepted start.
REQ-006 divisor  input  16  operand B; sampled on accepted start.
REQ-007 tx_data  output  8  byte presented to the UART byte transmitter.
REQ-008 tx_valid  output  1  tx_data is valid.
REQ-009 tx_ready  input  1  transmitter can take a byte.
REQ-010 rx_data  input  8  byte from the UART byte receiver.
REQ-011 rx_valid  input  1  one-cycle strobe; rx_data is valid.
REQ-012 busy  output  1  transaction in progress.
REQ-013 done  output  1  one-cycle pulse at the end of a transaction, whether it succeeded or timed out.
REQ-014 quotient  output  16  last successfully received quotient.
REQ-015 remainder  output  16  last successfully received remainder.
REQ-016 timeout_err  output  1  status of the last transaction: 1 if it timed out; valid from done onward.

Function
REQ-017 The state machine SHALL have states IDLE, SEND, RECV and FIN.
REQ-018 In IDLE with start=1: latch the operands, set byte index to 0, go to SEND, and assert busy from the next cycle.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 In SEND, tx_valid=1 with bytes in this order: dividend[7:0], dividend[15:8], divisor[7:0], divisor[15:8].
REQ-021 A byte transfers on a cycle where tx_valid && tx_ready.
- tx_data stays stable and tx_valid stays high until the byte transfers.
- The next byte, if any, may be presented on the following cycle.
REQ-022 After the 4th byte transfers: tx_valid=0, receive index reset to 0, timeout counter cleared, go to RECV.
REQ-023 rx_valid SHALL be ignored in IDLE, SEND and FIN.
REQ-024 In RECV, each rx_valid stores rx_data into a shadow register in this order: quotient[7:0], quotient[15:8], remainder[7:0], remainder[15:8].
- Each rx_valid also clears the timeout counter.
REQ-025 On the 4th byte:
- quotient and remainder are updated from the shadow registers (the 4th byte included) on that same edge.
- timeout_err=0; go to FIN.
REQ-026 In RECV without rx_valid, the timeout counter increments.
- When it reaches TIMEOUT_MAX-1: timeout_err=1, quotient/remainder unchanged, go to FIN.
REQ-027 rx_valid SHALL take priority over timeout when both occur on the same cycle.
REQ-028 FIN asserts done=1 for exactly one cycle, clears busy, and returns to IDLE.
- A start in that FIN cycle is ignored.
- A start in the next cycle (IDLE) is accepted.
REQ-029 Latency: done occurs 1 cycle after the 4th rx_valid.
REQ-030 Divisor 0 SHALL be transmitted unchanged, with no local check.
REQ-031 The timeout counter SHALL be wide enough for TIMEOUT_MAX and SHALL NOT wrap.

Reset
REQ-032 rst=1 at a clock edge SHALL force, by the next edge:
- IDLE; tx_valid=0, tx_data=0, busy=0, done=0;
- quotient=0, remainder=0, timeout_err=0;
- all indices, counters and shadow registers =0.
REQ-033 Reset mid-transaction SHALL abort it with no done pulse; the partial result is discarded.

Verification
REQ-034 Nominal divide.
- Stimulus: start with dividend=0x03E8, divisor=0x0007, tx_ready=1.
- Expect tx bytes E8,03,07,00.
- Reply 8E,00,06,00 → done with quotient=0x008E, remainder=0x0006, timeout_err=0.
REQ-035 Divide by zero.
- Stimulus: dividend=0x1234, divisor=0.
- Expect tx bytes 34,12,00,00.
- Reply FF,FF,34,12 → quotient=0xFFFF, remainder=0x1234.
REQ-036 Backpressure.
- Stimulus: tx_ready=0 for 10 cycles during byte 2.
- Expect tx_data=0x03 and tx_valid held throughout; no byte lost or duplicated; 4 transfers in total.
REQ-037 Timeout.
- Stimulus: TIMEOUT_MAX=100; prior result q=0x008E; reply only 2 bytes.
- Expect done with timeout_err=1 exactly 100 cycles after the 2nd rx_valid; quotient stays 0x008E.
REQ-038 Protocol misuse.
- Stimulus: start pulsed during SEND and RECV; stray rx_valid during SEND.
- Expect: no effect; the transaction completes per REQ-034.
REQ-039 Reset mid-RECV.
- Stimulus: rst after 2 reply bytes.
- Expect all outputs 0 and no done pulse.
- A new transaction then completes normally.
